// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of regfile_arbiter: two requesters (core, debug),
// each with req/we/addr/wdata and a one-cycle grant, plus a shared
// response (rdata/err) and a busy flag.
//   master : drives requests, observes grants/response (requester side)
//   slave  : observes requests, drives grants/response (arbiter side)
interface regfile_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [3:0]  c_addr;
  logic [31:0] c_wdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_addr;
  logic [31:0] d_wdata;
  logic        c_gnt;
  logic        d_gnt;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    input  c_gnt, d_gnt, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    output c_gnt, d_gnt, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Arbitrates register-file access between a core requester and a debug
// requester. One transaction at a time: IDLE picks a winner (round-robin on
// ties), then WRITE drives the write port for one cycle, or READ holds the
// read address for RD_LAT+1 cycles and captures rf_RD1, then DONE pulses the
// winner's grant. Writes to r0 (hardwired) and r15 (PC) are rejected with
// rsp_err. All outputs are registered.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   bus (slave)      requester handshake and response (see regfile_arbiter_if)
//   rf_A1 / rf_RD1   register-file read address / read data
//   rf_A3, rf_WD3,   register-file write address, data, enable
//   rf_WE3
module regfile_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_arbiter_if.slave     bus,
  output logic [3:0]           rf_A1,
  output logic [3:0]           rf_A3,
  output logic [31:0]          rf_WD3,
  output logic                 rf_WE3,
  input  logic [31:0]          rf_RD1
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_LAT);

  state_t      state;
  logic        last_dbg;   // 1 = debug was served last
  logic        cur_dbg;    // winner of the transaction in flight
  logic [2:0]  cnt;

  logic        win_dbg;
  logic        sel_we;
  logic [3:0]  sel_addr;
  logic [31:0] sel_wdata;

  always_comb begin
    win_dbg   = bus.d_req && (!bus.c_req || !last_dbg);
    sel_we    = win_dbg ? bus.d_we    : bus.c_we;
    sel_addr  = win_dbg ? bus.d_addr  : bus.c_addr;
    sel_wdata = win_dbg ? bus.d_wdata : bus.c_wdata;
  end

  // The latched address/data live directly in rf_A1 (reads) or rf_A3/rf_WD3
  // (writes), loaded on the edge that leaves IDLE; later bus changes are
  // therefore ignored without separate shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_dbg      <= 1'b1;
      cur_dbg       <= 1'b0;
      cnt           <= '0;
      bus.c_gnt     <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      rf_A1         <= '0;
      rf_A3         <= '0;
      rf_WD3        <= '0;
      rf_WE3        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.c_req || bus.d_req) begin
            cur_dbg  <= win_dbg;
            bus.busy <= 1'b1;
            if (sel_we) begin
              if (sel_addr == 4'd0 || sel_addr == 4'd15) begin
                state       <= DONE;
                bus.rsp_err <= 1'b1;
                bus.c_gnt   <= !win_dbg;
                bus.d_gnt   <= win_dbg;
                last_dbg    <= win_dbg;
              end else begin
                state  <= WRITE;
                rf_WE3 <= 1'b1;
                rf_A3  <= sel_addr;
                rf_WD3 <= sel_wdata;
              end
            end else begin
              state <= READ;
              rf_A1 <= sel_addr;
              cnt   <= '0;
            end
          end
        end
        WRITE: begin
          rf_WE3    <= 1'b0;
          state     <= DONE;
          bus.c_gnt <= !cur_dbg;
          bus.d_gnt <= cur_dbg;
          last_dbg  <= cur_dbg;
        end
        READ: begin
          if (cnt == RD_LAST) begin
            bus.rsp_rdata <= rf_RD1;
            state         <= DONE;
            bus.c_gnt     <= !cur_dbg;
            bus.d_gnt     <= cur_dbg;
            last_dbg      <= cur_dbg;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          bus.c_gnt   <= 1'b0;
          bus.d_gnt   <= 1'b0;
          bus.rsp_err <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  rf_A1;
  logic [3:0]  rf_A3;
  logic [31:0] rf_WD3;
  logic        rf_WE3;
  logic [31:0] rf_RD1;
  logic [31:0] regs [16];

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_arbiter_if bus();

  regfile_arbiter #(.RD_LAT(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rf_A1  (rf_A1),
    .rf_A3  (rf_A3),
    .rf_WD3 (rf_WD3),
    .rf_WE3 (rf_WE3),
    .rf_RD1 (rf_RD1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: writes on rising edge, read latch on falling edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'hA500_0000 | 32'(i);
      regs[3] <= 32'h0002_0100;
    end else if (rf_WE3) begin
      regs[rf_A3] <= rf_WD3;
    end
  end

  always @(negedge clk) rf_RD1 <= regs[rf_A1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drop_reqs();
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  // One transaction from a single requester. Request is dropped and the
  // addr/wdata scrambled one cycle after sampling; the transaction must
  // still complete using the latched values.
  task automatic run_txn(input string nm, input bit dbg, input bit we,
                         input logic [3:0] addr, input logic [31:0] wd,
                         input bit exp_err, input logic [31:0] exp_rd,
                         input int exp_lat);
    int k = 0;
    int we_cnt = 0;
    bit got = 0;
    int exp_we;
    @(negedge clk);
    if (dbg) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
    end
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        drop_reqs();
        bus.c_addr = ~addr; bus.d_addr = ~addr;
        bus.c_wdata = ~wd;  bus.d_wdata = ~wd;
      end
      if (rf_WE3) begin
        we_cnt++;
        chk({nm, " A3"}, 32'(rf_A3), 32'(addr));
        chk({nm, " WD3"}, rf_WD3, wd);
      end
      if (bus.c_gnt || bus.d_gnt) begin
        got = 1;
        chk({nm, " lat"}, 32'(k), 32'(exp_lat));
        chk({nm, " gnt"}, {30'd0, bus.c_gnt, bus.d_gnt}, dbg ? 32'd1 : 32'd2);
        chk({nm, " err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({nm, " busy"}, 32'(bus.busy), 32'd1);
        if (!we) begin
          chk({nm, " rdata"}, bus.rsp_rdata, exp_rd);
          chk({nm, " A1"}, 32'(rf_A1), 32'(addr));
        end
      end
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL %s timeout: got no gnt expected gnt within 20 cycles", nm);
    end
    exp_we = (we && addr != 4'd0 && addr != 4'd15) ? 1 : 0;
    chk({nm, " we_cnt"}, 32'(we_cnt), 32'(exp_we));
    @(negedge clk);
    chk({nm, " post gnt"}, {30'd0, bus.c_gnt, bus.d_gnt}, 32'd0);
    chk({nm, " post busy"}, 32'(bus.busy), 32'd0);
    chk({nm, " post err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  typedef struct {
    bit          dbg;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int g;
    int k;
    int last_k;
    int idle_k;
    bit seen;

    vecs[0] = '{0, 1, 4'd5,  32'hDEAD_BEEF, 0, 32'h0,         2};
    vecs[1] = '{1, 0, 4'd3,  32'h0,         0, 32'h0002_0100, 3};
    vecs[2] = '{0, 0, 4'd5,  32'h0,         0, 32'hDEAD_BEEF, 3};
    vecs[3] = '{1, 1, 4'd15, 32'h1111_2222, 1, 32'h0,         1};
    vecs[4] = '{0, 1, 4'd0,  32'h3333_4444, 1, 32'h0,         1};
    vecs[5] = '{1, 1, 4'd14, 32'h1234_5678, 0, 32'h0,         2};
    vecs[6] = '{0, 0, 4'd14, 32'h0,         0, 32'h1234_5678, 3};
    vecs[7] = '{1, 0, 4'd0,  32'h0,         0, 32'hA500_0000, 3};
    vecs[8] = '{0, 0, 4'd15, 32'h0,         0, 32'hA500_000F, 3};

    rst = 1'b1;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);

    chk("reset busy",  32'(bus.busy), 32'd0);
    chk("reset gnt",   {30'd0, bus.c_gnt, bus.d_gnt}, 32'd0);
    chk("reset rdata", bus.rsp_rdata, 32'd0);
    chk("reset err",   32'(bus.rsp_err), 32'd0);
    chk("reset rf",    {rf_A1, rf_A3, 23'd0, rf_WE3}, 32'd0);
    chk("reset WD3",   rf_WD3, 32'd0);
    rst = 1'b0;

    // Round-robin: both requesters held; core wins the first tie after reset.
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 4'd3;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 4'd14;
    g = 0; k = 0; last_k = 0; idle_k = -1;
    while (g < 4 && k < 60) begin
      @(negedge clk);
      k++;
      if (k == idle_k) chk("rr idle busy", 32'(bus.busy), 32'd0);
      if (bus.c_gnt || bus.d_gnt) begin
        chk("rr order", {30'd0, bus.c_gnt, bus.d_gnt}, g[0] ? 32'd1 : 32'd2);
        chk("rr rdata", bus.rsp_rdata, g[0] ? 32'hA500_000E : 32'h0002_0100);
        if (g == 0) chk("rr first lat", 32'(k), 32'd3);
        else        chk("rr gap", 32'(k - last_k), 32'd4);
        last_k = k;
        idle_k = k + 1;
        g++;
        if (g == 4) drop_reqs();
      end
    end
    if (g < 4) begin
      total_cnt++;
      $display("FAIL rr timeout: got %0d grants expected 4", g);
      drop_reqs();
    end
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].dbg, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].err, vecs[i].rdata, vecs[i].lat);

    // Reset in the middle of a read: outputs clear at once, no grant.
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 4'd3;
    @(negedge clk);
    drop_reqs();
    chk("mid busy before rst", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst A1",   32'(rf_A1), 32'd0);
    chk("mid rst rdata", bus.rsp_rdata, 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.c_gnt || bus.d_gnt) seen = 1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.c_gnt || bus.d_gnt || bus.busy || rf_WE3) seen = 1;
    end
    chk("mid rst no gnt", 32'(seen), 32'd0);
    run_txn("post rst read", 0, 0, 4'd3, 32'h0, 0, 32'h0002_0100, 3);
    run_txn("post rst write", 1, 1, 4'd7, 32'hCAFE_F00D, 0, 32'h0, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
